// File: rtl/ibex_int_controller_multi.sv
// Multi-source interrupt controller: per-source level/edge capture, lowest-index
// arbitration, IDLE/PENDING/DONE ack/kill handshake. Optional NMI via IBEX_INT_CTRL_NMI_EN.
module ibex_int_controller_multi #(
  parameter int                 NUM_IRQ   = 32,
  parameter int                 ID_WIDTH  = 5,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  irq_en_i,
  input  logic                m_ie_i,
  input  logic                ctrl_ack_i,
  input  logic                ctrl_kill_i,
`ifdef IBEX_INT_CTRL_NMI_EN
  input  logic                irq_nmi_i,
  output logic                irq_nmi_ctrl_o,
`endif
  output logic                irq_req_ctrl_o,
  output logic [ID_WIDTH-1:0] irq_id_ctrl_o,
  output logic [NUM_IRQ-1:0]  irq_pending_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  cand;
  logic [ID_WIDTH-1:0] winner;
  logic                ack_clr;
  logic                nmi_pend;
  logic                nmi_flag_q, nmi_flag_d;

  assign cand = pend_q & irq_en_i;

  // Lowest-index candidate wins; scanning downward lets lower indices overwrite.
  always_comb begin
    winner = {ID_WIDTH{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      winner = cand[i] ? ID_WIDTH'(i) : winner;
    end
  end

  // Pending capture: level sources follow the line, edge sources latch until acked (set wins).
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        pend_d[i] = (irq_i[i] & ~irq_q[i]) |
                    (pend_q[i] & ~(ack_clr & ~nmi_flag_q & (irq_id_q == ID_WIDTH'(i))));
      end else begin
        pend_d[i] = irq_i[i];
      end
    end
  end

  // Request handshake FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    nmi_flag_d = nmi_flag_q;
    ack_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (nmi_pend) begin
          state_d    = PENDING;
          irq_id_d   = {ID_WIDTH{1'b0}};
          nmi_flag_d = 1'b1;
        end else if (m_ie_i && (|cand)) begin
          state_d    = PENDING;
          irq_id_d   = winner;
          nmi_flag_d = 1'b0;
        end else begin
          state_d    = IDLE;
        end
      end
      PENDING: begin
        if (ctrl_ack_i) begin
          state_d = DONE;
          ack_clr = 1'b1;
        end else if (ctrl_kill_i) begin
          state_d = IDLE;
        end else begin
          state_d = PENDING;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched ID and capture history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_id_q   <= {ID_WIDTH{1'b0}};
      pend_q     <= {NUM_IRQ{1'b0}};
      irq_q      <= {NUM_IRQ{1'b0}};
      nmi_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_id_q   <= irq_id_d;
      pend_q     <= pend_d;
      irq_q      <= irq_i;
      nmi_flag_q <= nmi_flag_d;
    end
  end

`ifdef IBEX_INT_CTRL_NMI_EN
  logic nmi_q;
  logic nmi_pend_q;

  // NMI edge capture; cleared only by an ack of the NMI request itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_q      <= irq_nmi_i;
      nmi_pend_q <= (irq_nmi_i & ~nmi_q) | (nmi_pend_q & ~(ack_clr & nmi_flag_q));
    end
  end

  assign nmi_pend       = nmi_pend_q;
  assign irq_nmi_ctrl_o = nmi_flag_q;
`else
  assign nmi_pend = 1'b0;
`endif

  assign irq_req_ctrl_o = (state_q == PENDING);
  assign irq_id_ctrl_o  = irq_id_q;
  assign irq_pending_o  = pend_q;

endmodule

// File: tb/tb_ibex_int_controller_multi.sv
// Directed plus randomized bench for ibex_int_controller_multi, checked against a
// cycle-level behavioural model of pending bits and the request handshake.
module tb_ibex_int_controller_multi;

  localparam int          N    = 32;
  localparam int          IDW  = 5;
  localparam logic [31:0] EDGE = 32'h00FF_0008;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   irq;
  logic [N-1:0]   en;
  logic           mie;
  logic           ack;
  logic           kill;
  logic           req_o;
  logic [IDW-1:0] id_o;
  logic [N-1:0]   pend_o;
`ifdef IBEX_INT_CTRL_NMI_EN
  logic           nmi = 1'b0;
  logic           nmi_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // behavioural model
  bit          m_req;
  bit          m_gap;
  int          m_id;
  logic [31:0] m_pend;
  logic [31:0] m_prev;

  ibex_int_controller_multi #(
    .NUM_IRQ  (N),
    .ID_WIDTH (IDW),
    .EDGE_MASK(EDGE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_i         (irq),
    .irq_en_i      (en),
    .m_ie_i        (mie),
    .ctrl_ack_i    (ack),
    .ctrl_kill_i   (kill),
`ifdef IBEX_INT_CTRL_NMI_EN
    .irq_nmi_i     (nmi),
    .irq_nmi_ctrl_o(nmi_o),
`endif
    .irq_req_ctrl_o(req_o),
    .irq_id_ctrl_o (id_o),
    .irq_pending_o (pend_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_req  = 1'b0;
    m_gap  = 1'b0;
    m_id   = 0;
    m_pend = 32'h0;
    m_prev = 32'h0;
  endtask

  // One clock of the model, using the inputs that were stable at the edge.
  task automatic model_update();
    logic [31:0] cand;
    logic [31:0] np;
    bit          ack_now;
    cand    = m_pend & en;
    ack_now = m_req && ack;
    for (int i = 0; i < N; i++) begin
      if (EDGE[i]) begin
        if (irq[i] && !m_prev[i]) np[i] = 1'b1;
        else if (ack_now && m_id == i) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else begin
        np[i] = irq[i];
      end
    end
    if (m_req) begin
      if (ack) begin
        m_req = 1'b0;
        m_gap = 1'b1;
      end else if (kill) begin
        m_req = 1'b0;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (mie && cand != 32'h0) begin
      m_req = 1'b1;
      for (int i = N - 1; i >= 0; i--) if (cand[i]) m_id = i;
    end
    m_pend = np;
    m_prev = irq;
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    cmp("req", {31'h0, req_o}, {31'h0, m_req});
    cmp("id", {27'h0, id_o}, 32'(m_id));
    cmp("pend", pend_o, m_pend);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b0;
    irq   = '0;
    en    = '0;
    mie   = 1'b0;
    ack   = 1'b0;
    kill  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("rst_req", {31'h0, req_o}, 32'h0);
    cmp("rst_id", {27'h0, id_o}, 32'h0);
    cmp("rst_pend", pend_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // priority between two level sources
    en = '1; mie = 1'b1; irq = 32'h0000_0C00;
    step();
    cmp("prio_early", {31'h0, req_o}, 32'h0);
    step();
    cmp("prio_req", {31'h0, req_o}, 32'h1);
    cmp("prio_id", {27'h0, id_o}, 32'd10);
    ack = 1'b1; step();
    cmp("done_gap", {31'h0, req_o}, 32'h0);
    ack = 1'b0; step(); step();
    cmp("rereq", {31'h0, req_o}, 32'h1);
    cmp("rereq_id", {27'h0, id_o}, 32'd10);
    kill = 1'b1; step();
    cmp("kill_idle", {31'h0, req_o}, 32'h0);
    cmp("kill_keep", pend_o, 32'h0000_0C00);
    kill = 1'b0; step();
    cmp("kill_rereq", {31'h0, req_o}, 32'h1);
    ack = 1'b1; irq = '0; step();
    ack = 1'b0; step(); step();

    // edge capture on source 3
    irq = 32'h8; step();
    irq = '0; step();
    cmp("edge_id", {27'h0, id_o}, 32'd3);
    step(); step();
    cmp("edge_hold", {31'h0, pend_o[3]}, 32'h1);
    ack = 1'b1; step();
    cmp("edge_clr", {31'h0, pend_o[3]}, 32'h0);
    ack = 1'b0; step(); step();
    irq = 32'h8; step();
    irq = '0; step();
    ack = 1'b1; irq = 32'h8; step();
    cmp("edge_setwins", {31'h0, pend_o[3]}, 32'h1);
    ack = 1'b0; irq = '0; step(); step();
    cmp("edge_again", {31'h0, req_o}, 32'h1);
    ack = 1'b1; kill = 1'b1; step();
    cmp("collide_req", {31'h0, req_o}, 32'h0);
    cmp("collide_clr", {31'h0, pend_o[3]}, 32'h0);
    ack = 1'b0; kill = 1'b0; step(); step();

    // masking by global and per-source enable
    mie = 1'b0; irq = 32'h2; step(); step(); step();
    cmp("mask_mie", {31'h0, req_o}, 32'h0);
    en = ~32'h2; mie = 1'b1; step(); step();
    cmp("mask_en", {31'h0, req_o}, 32'h0);
    en = '1; step();
    cmp("unmask_id", {27'h0, id_o}, 32'd1);
    cmp("unmask_req", {31'h0, req_o}, 32'h1);
    ack = 1'b1; irq = '0; step();
    ack = 1'b0; step(); step();

    // asynchronous reset in the middle of a request
    irq = 32'h5; step(); step();
    cmp("pre_rst_req", {31'h0, req_o}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("arst_req", {31'h0, req_o}, 32'h0);
    cmp("arst_id", {27'h0, id_o}, 32'h0);
    cmp("arst_pend", pend_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cmp("recapture", pend_o, 32'h5);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      irq  = $urandom & $urandom & $urandom;
      en   = $urandom | $urandom;
      mie  = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 2) == 0);
      kill = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
